// File: rtl/ev_indic_mc.sv
// Purpose : multi-channel event indicator; each detected src_ev event becomes a
//           dst_ev window counted in dst_clk transitions, so a slow domain sees it.
// Latency : trigger -> busy next src_clk edge; dst_ev after STRETCH-1 counted dst_clk
//           transitions (each seen SYNC src_clk edges after capture). No backpressure:
//           events during a window queue in a saturating counter; overflow is sticky.
// Ports   : src_clk/src_rstz  clock, async active-low reset
//           dst_clk           destination clock, sampled as data
//           src_ev[NCH]       event inputs
//           mode[2*NCH]       per channel {00 rise, 01 fall, 10 both, 11 level-high}
//           en[NCH]           channel enable (low also flushes pending events)
//           ovf_clr[NCH]      clear sticky overflow (a same-cycle set wins)
//           dst_ev[NCH]       stretched indication, busy[NCH] window in progress,
//           ovf[NCH]          sticky pending-queue overflow

module ev_indic_mc #(
   parameter int NCH     = 4,
   parameter int STRETCH = 8,
   parameter int PCNT_W  = 3,
   parameter int SYNC    = 2
) (
   input  logic             src_clk,
   input  logic             src_rstz,
   input  logic             dst_clk,
   input  logic [NCH-1:0]   src_ev,
   input  logic [2*NCH-1:0] mode,
   input  logic [NCH-1:0]   en,
   input  logic [NCH-1:0]   ovf_clr,
   output logic [NCH-1:0]   dst_ev,
   output logic [NCH-1:0]   busy,
   output logic [NCH-1:0]   ovf
);

   localparam int CNT_W = $clog2(2 * STRETCH);

   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(2 * STRETCH - 1);
   localparam logic [PCNT_W-1:0] PEND_ONE = PCNT_W'(1);
   localparam logic [PCNT_W-1:0] PEND_MAX = '1;

   localparam logic [1:0] MODE_RISE  = 2'b00;
   localparam logic [1:0] MODE_FALL  = 2'b01;
   localparam logic [1:0] MODE_BOTH  = 2'b10;
   localparam logic [1:0] MODE_LEVEL = 2'b11;

   // ------------------------------------------------------------------
   // Shared dst_clk sampler. s_q[0] is the raw capture; the compare of the
   // two oldest stages means a transition captured at edge e is counted at
   // edge e+SYNC, and both rising and falling dst_clk transitions count.
   // ------------------------------------------------------------------
   logic [SYNC:0] s_q;
   logic [SYNC:0] s_d;
   logic          dst_edge;

   always_comb begin
      s_d = {s_q[SYNC-1:0], dst_clk};
   end

   assign dst_edge = s_q[SYNC] ^ s_q[SYNC-1];

   always_ff @(posedge src_clk or negedge src_rstz) begin
      if (!src_rstz) begin
         s_q <= '0;
      end else begin
         s_q <= s_d;
      end
   end

   // ------------------------------------------------------------------
   // Per-channel trigger, window counter, pending queue and overflow flag.
   // cnt_q == 0 is idle; 1..2*STRETCH-1 is a window. The MSB of cnt_q is
   // the dst_ev output, so the low phase lasts STRETCH-1 transitions and the
   // high phase STRETCH transitions.
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic              d_ev_q;
      logic              d_ev_d;
      logic [CNT_W-1:0]  cnt_q;
      logic [CNT_W-1:0]  cnt_d;
      logic [PCNT_W-1:0] pend_q;
      logic [PCNT_W-1:0] pend_d;
      logic              ovf_q;
      logic              ovf_d;

      logic [1:0]        ch_mode;
      logic              idle;
      logic              wrap;
      logic              trg_raw;
      logic              trg;
      logic              ovf_set;

      assign ch_mode = mode[2*i +: 2];
      assign idle    = (cnt_q == '0);
      // Last counted transition of the window.
      assign wrap    = !idle && dst_edge && (cnt_q == CNT_LAST);

      always_comb begin
         case (ch_mode)
            MODE_RISE:  trg_raw = src_ev[i] & ~d_ev_q;
            MODE_FALL:  trg_raw = ~src_ev[i] & d_ev_q;
            MODE_BOTH:  trg_raw = src_ev[i] ^ d_ev_q;
            MODE_LEVEL: trg_raw = src_ev[i] & idle;
            default:    trg_raw = 1'b0;
         endcase
      end

      assign trg = trg_raw & en[i];

      // The edge history tracks src_ev even while disabled, so re-enabling
      // does not fire on a stale level.
      always_comb begin
         d_ev_d = src_ev[i];
      end

      always_comb begin
         cnt_d   = cnt_q;
         pend_d  = pend_q;
         ovf_set = 1'b0;

         if (idle) begin
            if (trg) begin
               cnt_d = CNT_ONE;
            end
         end else if (wrap) begin
            // A queued event restarts immediately; a trigger landing on this
            // same cycle takes the freed slot, so the queue depth is unchanged.
            // Level-mode triggers cannot occur here (they need idle), so level
            // mode always passes through one idle cycle between windows.
            if (pend_q != '0) begin
               cnt_d = CNT_ONE;
               if (!trg) begin
                  pend_d = pend_q - PEND_ONE;
               end
            end else if (trg) begin
               cnt_d = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end else begin
            if (dst_edge) begin
               cnt_d = cnt_q + CNT_ONE;
            end
            if (trg) begin
               if (pend_q == PEND_MAX) begin
                  ovf_set = 1'b1;
               end else begin
                  pend_d = pend_q + PEND_ONE;
               end
            end
         end

         // Disabling flushes the queue; the window in flight still completes.
         if (!en[i]) begin
            pend_d = '0;
         end

         // Set has priority over a coincident clear.
         ovf_d = ovf_set | (ovf_q & ~ovf_clr[i]);
      end

      always_ff @(posedge src_clk or negedge src_rstz) begin
         if (!src_rstz) begin
            d_ev_q <= 1'b0;
            cnt_q  <= '0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
         end else begin
            d_ev_q <= d_ev_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
         end
      end

      assign dst_ev[i] = cnt_q[CNT_W-1];
      assign busy[i]   = |cnt_q;
      assign ovf[i]    = ovf_q;
   end

endmodule

// File: tb/tb_ev_indic_mc.sv
// Purpose : self-checking bench for ev_indic_mc against a window-level reference model.
// Latency : checks every src_clk cycle on the falling edge.
// Backpressure: none; dst_clk is driven as data with each level held >= 2 src_clk cycles.

module tb_ev_indic_mc;

   localparam int NCH     = 4;
   localparam int STRETCH = 8;
   localparam int PCNT_W  = 2;
   localparam int SYNC    = 2;
   localparam int PMAX    = (1 << PCNT_W) - 1;
   // Counted transitions per window: STRETCH-1 low, STRETCH high.
   localparam int WIN_TR  = 2 * STRETCH - 1;

   logic             src_clk = 1'b0;
   logic             src_rstz;
   logic             dst_clk;
   logic [NCH-1:0]   src_ev;
   logic [2*NCH-1:0] mode;
   logic [NCH-1:0]   en;
   logic [NCH-1:0]   ovf_clr;
   logic [NCH-1:0]   dst_ev;
   logic [NCH-1:0]   busy;
   logic [NCH-1:0]   ovf;

   ev_indic_mc #(
      .NCH     (NCH),
      .STRETCH (STRETCH),
      .PCNT_W  (PCNT_W),
      .SYNC    (SYNC)
   ) u_dut (
      .src_clk  (src_clk),
      .src_rstz (src_rstz),
      .dst_clk  (dst_clk),
      .src_ev   (src_ev),
      .mode     (mode),
      .en       (en),
      .ovf_clr  (ovf_clr),
      .dst_ev   (dst_ev),
      .busy     (busy),
      .ovf      (ovf)
   );

   always #5 src_clk = ~src_clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: per channel, whether a window is open, how many
   // dst_clk transitions it has seen, how many windows are queued, and the
   // sticky overflow. dst_clk samples are kept as a history of values.
   // ------------------------------------------------------------------
   bit m_act  [NCH];
   int m_seen [NCH];
   int m_pend [NCH];
   bit m_ovf  [NCH];
   bit m_prev [NCH];
   bit m_hist [SYNC+1];

   function automatic void model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_act[i]  = 0;
         m_seen[i] = 0;
         m_pend[i] = 0;
         m_ovf[i]  = 0;
         m_prev[i] = 0;
      end
      for (int k = 0; k <= SYNC; k++) m_hist[k] = 0;
   endfunction

   function automatic void model_step();
      bit tr;
      bit s;
      bit t;
      bit last;
      bit set;
      // m_hist[k] holds the dst_clk sample taken k+1 edges ago.
      tr = m_hist[SYNC-1] ^ m_hist[SYNC];
      for (int k = SYNC; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = dst_clk;

      for (int i = 0; i < NCH; i++) begin
         s = src_ev[i];
         case (mode[2*i +: 2])
            2'd0:    t = s && !m_prev[i];
            2'd1:    t = !s && m_prev[i];
            2'd2:    t = s != m_prev[i];
            default: t = s && !m_act[i];
         endcase
         t   = t && en[i];
         set = 0;
         last = m_act[i] && tr && (m_seen[i] + 1 == WIN_TR);
         if (!m_act[i]) begin
            if (t) begin
               m_act[i]  = 1;
               m_seen[i] = 0;
            end
         end else if (last) begin
            if (m_pend[i] > 0) begin
               m_seen[i] = 0;
               if (!t) m_pend[i] = m_pend[i] - 1;
            end else if (t) begin
               m_seen[i] = 0;
            end else begin
               m_act[i] = 0;
            end
         end else begin
            if (tr) m_seen[i] = m_seen[i] + 1;
            if (t) begin
               if (m_pend[i] == PMAX) set = 1;
               else m_pend[i] = m_pend[i] + 1;
            end
         end
         m_ovf[i] = set || (m_ovf[i] && !ovf_clr[i]);
         if (!en[i]) m_pend[i] = 0;
         m_prev[i] = s;
      end
   endfunction

   function automatic logic [NCH-1:0] exp_dst();
      logic [NCH-1:0] r;
      for (int i = 0; i < NCH; i++) r[i] = m_act[i] && (m_seen[i] >= STRETCH - 1);
      return r;
   endfunction

   function automatic logic [NCH-1:0] exp_busy();
      logic [NCH-1:0] r;
      for (int i = 0; i < NCH; i++) r[i] = m_act[i];
      return r;
   endfunction

   function automatic logic [NCH-1:0] exp_ovf();
      logic [NCH-1:0] r;
      for (int i = 0; i < NCH; i++) r[i] = m_ovf[i];
      return r;
   endfunction

   // dst_clk generator state: each level held dst_lo..dst_hi src_clk cycles.
   int dst_ctr = 4;
   int dst_lo  = 4;
   int dst_hi  = 4;

   // One src_clk cycle: model follows the rising edge, outputs are checked
   // on the falling edge, then dst_clk is advanced; callers drive inputs after.
   task automatic tick();
      @(posedge src_clk);
      if (!src_rstz) model_reset();
      else model_step();
      @(negedge src_clk);
      chk("dst_ev", 32'(dst_ev), 32'(exp_dst()));
      chk("busy",   32'(busy),   32'(exp_busy()));
      chk("ovf",    32'(ovf),    32'(exp_ovf()));
      dst_ctr--;
      if (dst_ctr <= 0) begin
         dst_clk = ~dst_clk;
         dst_ctr = int'($urandom_range(dst_hi, dst_lo));
      end
   endtask

   task automatic pulse(input int ch, input int gap);
      src_ev[ch] = 1'b1;
      tick();
      src_ev[ch] = 1'b0;
      for (int k = 0; k < gap; k++) tick();
   endtask

   // Run until channel ch goes idle; report dst_ev rises and high cycles.
   task automatic run_idle(input int ch, input int max, output int rises, output int hi);
      logic p;
      bit   done;
      rises = 0;
      hi    = 0;
      done  = 0;
      p     = dst_ev[ch];
      for (int c = 0; c < max && !done; c++) begin
         tick();
         if (dst_ev[ch] && !p) rises++;
         if (dst_ev[ch]) hi++;
         p = dst_ev[ch];
         if (!busy[ch]) done = 1;
      end
      if (!done) chk("idle_timeout", 32'(busy[ch]), 32'd0);
   endtask

   task automatic wait_dst(input int ch, input int max);
      bit seen;
      seen = 0;
      for (int c = 0; c < max && !seen; c++) begin
         tick();
         if (dst_ev[ch]) seen = 1;
      end
      if (!seen) chk("dst_timeout", 32'(dst_ev[ch]), 32'd1);
   endtask

   int rises;
   int hi;

   initial begin
      src_rstz = 1'b0;
      dst_clk  = 1'b0;
      src_ev   = '0;
      mode     = '0;
      en       = '1;
      ovf_clr  = '0;
      model_reset();
      for (int k = 0; k < 3; k++) tick();
      chk("rst_dst_ev", 32'(dst_ev), 32'd0);
      chk("rst_busy",   32'(busy),   32'd0);
      chk("rst_ovf",    32'(ovf),    32'd0);
      src_rstz = 1'b1;
      for (int k = 0; k < 4; k++) tick();

      // 1: single rise pulse on channel 0, dst_clk = src_clk/8
      src_ev[0] = 1'b1;
      tick();
      chk("s1_busy_next", 32'(busy[0]), 32'd1);
      src_ev[0] = 1'b0;
      run_idle(0, 400, rises, hi);
      chk("s1_windows", 32'(rises), 32'd1);
      chk("s1_high_cycles", 32'(hi), 32'(STRETCH * 4));
      chk("s1_others_busy", 32'(busy[NCH-1:1]), 32'd0);

      // 2: burst of three pulses, four cycles apart
      for (int k = 0; k < 3; k++) pulse(0, 3);
      run_idle(0, 1000, rises, hi);
      chk("s2_windows", 32'(rises), 32'd3);
      chk("s2_high_cycles", 32'(hi), 32'(3 * STRETCH * 4));
      chk("s2_ovf", 32'(ovf[0]), 32'd0);

      // 3: overflow with a 2-bit queue
      for (int k = 0; k < 6; k++) pulse(0, 2);
      chk("s3_ovf_set", 32'(ovf[0]), 32'd1);
      run_idle(0, 1500, rises, hi);
      chk("s3_windows", 32'(rises), 32'd4);
      ovf_clr[0] = 1'b1;
      tick();
      ovf_clr[0] = 1'b0;
      chk("s3_ovf_clr", 32'(ovf[0]), 32'd0);
      for (int k = 0; k < 4; k++) pulse(0, 2);
      src_ev[0]  = 1'b1;
      ovf_clr[0] = 1'b1;
      tick();
      src_ev[0]  = 1'b0;
      ovf_clr[0] = 1'b0;
      chk("s3_set_wins", 32'(ovf[0]), 32'd1);
      run_idle(0, 1500, rises, hi);

      // 4: modes on channel 2
      mode[5:4] = 2'b11;
      src_ev[2] = 1'b1;
      rises = 0;
      for (int k = 0; k < 180; k++) begin
         logic p;
         p = dst_ev[2];
         tick();
         if (dst_ev[2] && !p) rises++;
      end
      chk("s4_level_windows", 32'(rises), 32'd3);
      src_ev[2] = 1'b0;
      run_idle(2, 400, rises, hi);
      mode[5:4] = 2'b01;
      tick();
      src_ev[2] = 1'b1;
      tick();
      chk("s4_fall_no_rise", 32'(busy[2]), 32'd0);
      tick();
      src_ev[2] = 1'b0;
      tick();
      chk("s4_fall_trig", 32'(busy[2]), 32'd1);
      run_idle(2, 400, rises, hi);
      chk("s4_fall_windows", 32'(rises), 32'd1);
      mode[5:4] = 2'b10;
      tick();
      src_ev[2] = 1'b1;
      tick();
      chk("s4_both_trig", 32'(busy[2]), 32'd1);
      tick();
      src_ev[2] = 1'b0;
      run_idle(2, 800, rises, hi);
      chk("s4_both_windows", 32'(rises), 32'd2);

      // 5: enable on channel 1
      for (int k = 0; k < 3; k++) pulse(1, 3);
      wait_dst(1, 200);
      en[1] = 1'b0;
      run_idle(1, 400, rises, hi);
      chk("s5_no_more_windows", 32'(rises), 32'd0);
      pulse(1, 2);
      chk("s5_disabled_pulse", 32'(busy[1]), 32'd0);
      pulse(1, 2);
      chk("s5_disabled_pulse2", 32'(busy[1]), 32'd0);
      en[1] = 1'b1;
      for (int k = 0; k < 4; k++) tick();

      // 6: reset mid-window with queued events on channel 3
      for (int k = 0; k < 3; k++) pulse(3, 3);
      wait_dst(3, 200);
      src_rstz = 1'b0;
      #1;
      chk("s6_rst_dst_ev", 32'(dst_ev), 32'd0);
      chk("s6_rst_busy",   32'(busy),   32'd0);
      chk("s6_rst_ovf",    32'(ovf),    32'd0);
      tick();
      src_rstz = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      pulse(3, 0);
      run_idle(3, 400, rises, hi);
      chk("s6_windows", 32'(rises), 32'd1);
      chk("s6_high_cycles", 32'(hi), 32'(STRETCH * 4));

      // 7: randomized traffic with irregular dst_clk
      dst_lo = 2;
      dst_hi = 6;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(5, 0) == 0) src_ev[i] = ~src_ev[i];
            if ($urandom_range(199, 0) == 0) mode[2*i +: 2] = 2'($urandom_range(3, 0));
            if ($urandom_range(299, 0) == 0) en[i] = ~en[i];
            ovf_clr[i] = ($urandom_range(19, 0) == 0);
         end
         src_rstz = ($urandom_range(1999, 0) != 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
